// File: rtl/alu_ex_stage.sv
// MIPS execute stage: ALU, BEQ evaluation and branch-target adder feeding the EX/MEM register.
// Flush overrides stall; a captured bubble keeps its data fields but never its control bits.
module alu_ex_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [3:0]          alu_control,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [WIDTH-1:0]    imm,
  input  logic                alu_src,
  input  logic [WIDTH-1:0]    pc_plus4,
  input  logic                branch,
  input  logic [REG_BITS-1:0] rd,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                ex_valid,
  output logic [WIDTH-1:0]    ex_result,
  output logic                ex_zero,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch_taken,
  output logic [WIDTH-1:0]    ex_branch_target
);

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] target;
  logic             alu_zero;
  logic             load_data;

  always_comb begin
    op_b = alu_src ? imm : operand_b;
    case (alu_control)
      4'b0000: alu_res = operand_a & op_b;
      4'b0001: alu_res = operand_a | op_b;
      4'b0010: alu_res = operand_a + op_b;
      4'b0011: alu_res = operand_a ^ op_b;
      4'b0110: alu_res = operand_a - op_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  assign alu_zero  = (alu_res == '0);
  assign target    = pc_plus4 + {imm[WIDTH-3:0], 2'b00};
  // Data fields still load on flush so the killed slot holds deterministic values.
  assign load_data = flush || !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_result        <= '0;
      ex_zero          <= 1'b0;
      ex_store_data    <= '0;
      ex_rd            <= '0;
      ex_reg_write     <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_branch_taken  <= 1'b0;
      ex_branch_target <= '0;
    end else begin
      if (load_data) begin
        ex_result        <= alu_res;
        ex_zero          <= alu_zero;
        ex_store_data    <= operand_b;
        ex_rd            <= rd;
        ex_branch_target <= target;
      end
      if (flush) begin
        ex_valid        <= 1'b0;
        ex_reg_write    <= 1'b0;
        ex_mem_read     <= 1'b0;
        ex_mem_write    <= 1'b0;
        ex_branch_taken <= 1'b0;
      end else if (!stall) begin
        ex_valid        <= in_valid;
        ex_reg_write    <= in_valid & reg_write;
        ex_mem_read     <= in_valid & mem_read;
        ex_mem_write    <= in_valid & mem_write;
        ex_branch_taken <= in_valid & branch & alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: stimulus pushes the predicted EX/MEM state per cycle,
// a monitor pops and compares after every rising edge.
module tb_alu_ex_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0] alu_control = '0;
  logic [W-1:0] operand_a = '0, operand_b = '0, imm = '0, pc_plus4 = '0;
  logic alu_src = 1'b0, branch = 1'b0;
  logic [4:0] rd = '0;
  logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;

  logic ex_valid, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_taken;
  logic [W-1:0] ex_result, ex_store_data, ex_branch_target;
  logic [4:0] ex_rd;

  alu_ex_stage #(.WIDTH(W), .REG_BITS(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
    .alu_src(alu_src), .pc_plus4(pc_plus4), .branch(branch), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] store;
    logic [4:0]   rd;
    logic         rw, mr, mw, taken;
    logic [W-1:0] target;
  } st_t;

  st_t model;
  st_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input st_t e);
    chk({tag, " valid"}, W'(ex_valid), W'(e.valid));
    chk({tag, " result"}, ex_result, e.result);
    chk({tag, " zero"}, W'(ex_zero), W'(e.zero));
    chk({tag, " store_data"}, ex_store_data, e.store);
    chk({tag, " rd"}, W'(ex_rd), W'(e.rd));
    chk({tag, " reg_write"}, W'(ex_reg_write), W'(e.rw));
    chk({tag, " mem_read"}, W'(ex_mem_read), W'(e.mr));
    chk({tag, " mem_write"}, W'(ex_mem_write), W'(e.mw));
    chk({tag, " branch_taken"}, W'(ex_branch_taken), W'(e.taken));
    chk({tag, " branch_target"}, ex_branch_target, e.target);
  endtask

  function automatic st_t empty_state();
    st_t s;
    s = '{valid: 1'b0, result: '0, zero: 1'b0, store: '0, rd: '0, rw: 1'b0, mr: 1'b0,
          mw: 1'b0, taken: 1'b0, target: '0};
    return s;
  endfunction

  // Reference: what the EX/MEM slot should hold after the coming edge.
  function automatic st_t predict(input st_t cur);
    st_t n;
    logic [W-1:0] b, r;
    longint sa, sb;
    n = cur;
    b = alu_src ? imm : operand_b;
    sa = longint'($signed(operand_a));
    sb = longint'($signed(b));
    case (alu_control)
      4'd0:    r = operand_a & b;
      4'd1:    r = operand_a | b;
      4'd2:    r = W'((64'(operand_a) + 64'(b)) % 64'h1_0000_0000);
      4'd3:    r = operand_a ^ b;
      4'd6:    r = W'((64'(operand_a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd7:    r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    if (flush || !stall) begin
      n.result = r;
      n.zero   = (r == 0);
      n.store  = operand_b;
      n.rd     = rd;
      n.target = W'((64'(pc_plus4) + 64'(imm) * 4) % 64'h1_0000_0000);
    end
    if (flush) begin
      n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.taken = 0;
    end else if (!stall) begin
      n.valid = in_valid;
      n.rw    = in_valid && reg_write;
      n.mr    = in_valid && mem_read;
      n.mw    = in_valid && mem_write;
      n.taken = in_valid && branch && (r == 0);
    end
    return n;
  endfunction

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic apply();
    model = predict(model);
    exp_q.push_back(model);
    @(negedge clk);
  endtask

  task automatic op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic s, input logic [W-1:0] i);
    alu_control = c; operand_a = a; operand_b = b; alu_src = s; imm = i;
    in_valid = 1; stall = 0; flush = 0; branch = 0; pc_plus4 = 32'h400;
    rd = 5'd3; reg_write = 1; mem_read = 0; mem_write = 0;
  endtask

  // Monitor: the slot is presented every cycle; compare whatever was predicted for it.
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_state("slot", e);
      end
    end
  end

  initial begin
    logic [3:0] codes[8];
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd5, 4'd15};
    model = empty_state();
    #12 chk_state("reset_initial", empty_state());
    @(negedge clk);
    reset = 0;

    op(4'd2, 32'hF, 32'h3, 0, 0); apply();
    op(4'd6, 32'hF, 32'h3, 0, 0); apply();
    op(4'd0, 32'hF, 32'h3, 0, 0); apply();
    op(4'd1, 32'hF, 32'h3, 0, 0); apply();
    op(4'd3, 32'hF, 32'h3, 0, 0); apply();
    op(4'd7, 32'hFFFF_FFFF, 32'h1, 0, 0); apply();
    op(4'd2, 32'hFFFF_FFFF, 32'h1, 0, 0); apply();

    op(4'd6, 32'h1234, 32'h1234, 0, 32'hFFFF_FFFE); branch = 1; pc_plus4 = 32'h100; apply();
    op(4'd6, 32'h1234, 32'h1235, 0, 32'hFFFF_FFFE); branch = 1; pc_plus4 = 32'h100; apply();
    op(4'd2, 32'h10, 32'h55, 1, 32'hFFFF_FFFC); rd = 5'd7; apply();

    // Capture, three stalled cycles with churning inputs, then flush+stall.
    op(4'd2, 32'h20, 32'h22, 0, 0); mem_write = 1; apply();
    for (int k = 0; k < 3; k++) begin
      op(4'd3, $urandom, $urandom, 1'($urandom), $urandom); stall = 1; mem_read = 1; apply();
    end
    op(4'd1, 32'hA0, 32'h0B, 0, 0); stall = 1; flush = 1; mem_read = 1; apply();

    // Bubble with live control inputs and a branch whose condition holds.
    op(4'd6, 32'h77, 32'h77, 0, 32'h4); in_valid = 0; mem_write = 1; branch = 1; apply();

    // Asynchronous reset mid-cycle while stalled, with a valid slot held.
    op(4'd2, 32'h5, 32'h6, 0, 0); mem_read = 1; apply();
    stall = 1; reset = 1;
    #1 chk_state("reset_async", empty_state());
    @(posedge clk); #1 chk_state("reset_held", empty_state());
    @(negedge clk);
    reset = 0;
    model = empty_state();
    op(4'd2, 32'h9, 32'h9, 0, 0); stall = 1; apply();

    for (int k = 0; k < 200; k++) begin
      logic [W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'(k) : $urandom;
      op(codes[$urandom_range(0, 7)], a, ($urandom_range(0, 3) == 0) ? a : $urandom,
         1'($urandom), $urandom);
      in_valid = ($urandom_range(0, 4) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      branch = 1'($urandom); reg_write = 1'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      rd = 5'($urandom); pc_plus4 = $urandom;
      apply();
    end

    repeat (3) @(posedge clk);
    #2 chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage datapath of the MIPS pipeline, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code plus operands and performs the ALU operation.
- Evaluates the BEQ condition and computes the branch target.
- Captures everything into the EX/MEM pipeline register, with stall and flush control.

Parameters:
- WIDTH, 32, datapath width in bits.
- REG_BITS, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ID/EX slot holds a real instruction
- stall  input  1  hold the EX/MEM register contents
- flush  input  1  kill the instruction being captured this cycle
- alu_control  input  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT
- operand_a  input  WIDTH  rs value (already forwarded)
- operand_b  input  WIDTH  rt value (already forwarded)
- imm  input  WIDTH  immediate, already sign- or zero-extended by decode
- alu_src  input  1  1: B operand = imm; 0: B operand = operand_b
- pc_plus4  input  WIDTH  PC+4 of this instruction
- branch  input  1  instruction is BEQ
- rd  input  REG_BITS  destination register
- reg_write, mem_read, mem_write  input  1 each  control bits passed through
- ex_valid  output  1  EX/MEM slot valid
- ex_result  output  WIDTH  registered ALU result
- ex_zero  output  1  registered (ALU result == 0)
- ex_store_data  output  WIDTH  registered operand_b, used as store data
- ex_rd  output  REG_BITS  registered rd
- ex_reg_write, ex_mem_read, ex_mem_write  output  1 each  registered, qualified by valid
- ex_branch_taken  output  1  registered: branch & zero & in_valid
- ex_branch_target  output  WIDTH  registered: pc_plus4 + (imm << 2)

Behaviour:
- Reset (asynchronous, active-high): every output goes to 0 immediately and stays 0 while reset is high.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- ALU operations:
  - B = alu_src ? imm : operand_b.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow detection or trap.
  - AND/OR/XOR are bitwise.
  - SLT is a signed two's-complement compare; result is 1 or 0, zero-extended.
  - Any other alu_control code gives result 0 (zero=1); this never raises branch_taken unless branch=1.
- Zero flag: ex_zero reflects the result of the op actually selected. BEQ relies on the decoder supplying SUB.
- Branch:
  - branch_taken = branch & in_valid & zero.
  - Target is computed with a wrapping add. It is computed and registered for every instruction; consumers gate it with ex_branch_taken.
- Register update priority, each edge:
  1. flush=1: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch_taken all load 0. Data fields (result, store_data, rd, target, zero) load normally. Flush overrides stall.
  2. stall=1 (no flush): every output register holds its value.
  3. Otherwise: capture. If in_valid=0, the slot becomes a bubble: ex_valid and all four control outputs load 0; data fields load normally.
- Control outputs are never 1 while ex_valid=0.
- Reset mid-stall: reset wins; after release the register is empty (ex_valid=0). Stall must be re-asserted by upstream logic if still needed.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with valid data captured -> all outputs 0 before the next clock edge; stay 0 until release.
- ALU ops, alu_src=0:
  - A=0x0000000F, B=0x00000003: ADD -> 0x12; SUB -> 0x0C; AND -> 0x03; OR -> 0x0F; XOR -> 0x0C.
  - A=0xFFFFFFFF, B=1: SLT -> 1 (signed); ADD -> 0x00000000 with ex_zero=1.
- Branch: branch=1, ctrl=0110, A=B=0x1234, pc_plus4=0x100, imm=0xFFFFFFFE -> ex_branch_taken=1, ex_branch_target=0xF8. Same with A!=B -> taken=0.
- Immediate path: alu_src=1, ctrl=0010, A=0x10, imm=0xFFFFFFFC, reg_write=1, rd=7 -> ex_result=0x0C, ex_rd=7, ex_reg_write=1, ex_valid=1.
- Stall/flush:
  - Capture op X, then stall for 3 cycles while inputs change -> outputs unchanged.
  - Then assert flush+stall together -> ex_valid=0, all control outputs 0.
- Bubble: in_valid=0 with mem_write=1, branch=1, A=B -> ex_valid=0, ex_mem_write=0, ex_branch_taken=0.
